// File: rtl/switch_nport_mc.sv
// N-port single-beat packet switch: per-input FIFOs, all-or-nothing multicast delivery,
// round-robin priority with output reservation, ready/valid on every port.
module switch_nport_mc #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           in_valid,
  output logic [NUM_PORTS-1:0]           in_ready,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] in_src,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] in_tgt,
  input  logic [NUM_PORTS*DATA_W-1:0]    in_data,
  output logic [NUM_PORTS-1:0]           out_valid,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic [NUM_PORTS*NUM_PORTS-1:0] out_src,
  output logic [NUM_PORTS*DATA_W-1:0]    out_data,
  output logic [NUM_PORTS-1:0]           drop_pulse
);
  localparam int unsigned N  = NUM_PORTS;
  localparam int unsigned PW = $clog2(NUM_PORTS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [N-1:0]      src;
    logic [N-1:0]      tgt;
    logic [DATA_W-1:0] data;
  } pkt_t;

  pkt_t              mem    [N][FIFO_DEPTH];
  logic [AW:0]       wr_ptr [N];
  logic [AW:0]       rd_ptr [N];
  pkt_t              head   [N];
  logic [PW-1:0]     rr_ptr;
  logic [N-1:0]      empty, full, push, free, grant, drop;
  logic [N-1:0]      claimed, resv, load;
  logic [PW-1:0]     prio, idx;
  logic              prio_vld;
  logic [PW:0]       sum;
  logic [N-1:0]      load_src  [N];
  logic [DATA_W-1:0] load_data [N];

  // FIFO heads and occupancy flags (extra wrap bit distinguishes full from empty)
  always_comb begin
    for (int i = 0; i < N; i++) begin
      head[i]  = mem[i][rd_ptr[i][AW-1:0]];
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
    end
  end

  assign in_ready   = ~full & {N{~rst}};
  assign push       = in_valid & in_ready;
  assign free       = ~out_valid | out_ready;
  assign drop_pulse = drop & {N{~rst}};

  // Scan from rr_ptr; the first non-empty head is the priority input and reserves its outputs
  always_comb begin
    grant    = '0;
    claimed  = '0;
    resv     = '0;
    prio     = '0;
    prio_vld = 1'b0;
    idx      = '0;
    sum      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!empty[idx]) begin
        if (!prio_vld) begin
          prio_vld = 1'b1;
          prio     = idx;
          resv     = head[idx].tgt;
        end
        if (((head[idx].tgt & ~free) == '0) &&
            ((head[idx].tgt & claimed) == '0) &&
            ((idx == prio) || ((head[idx].tgt & resv) == '0))) begin
          grant[idx] = 1'b1;
          claimed    = claimed | head[idx].tgt;
        end
      end
    end
  end

  // Fan granted heads out to every targeted output; an empty mask is a drop
  always_comb begin
    load = '0;
    drop = '0;
    for (int j = 0; j < N; j++) begin
      load_src[j]  = '0;
      load_data[j] = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        if (head[i].tgt == '0) drop[i] = 1'b1;
        for (int j = 0; j < N; j++) begin
          if (head[i].tgt[j]) begin
            load[j]      = 1'b1;
            load_src[j]  = head[i].src;
            load_data[j] = head[i].data;
          end
        end
      end
    end
  end

  // FIFO storage; loopback bit stripped on entry
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i][AW-1:0]] <= {in_src[i*N +: N],
                                      in_tgt[i*N +: N] & ~(N'(1) << i),
                                      in_data[i*DATA_W +: DATA_W]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr    <= '0;
      out_valid <= '0;
      out_src   <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + (AW+1)'(1);
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + (AW+1)'(1);
      end
      for (int j = 0; j < N; j++) begin
        if (load[j]) begin
          out_valid[j]                  <= 1'b1;
          out_src[j*N +: N]             <= load_src[j];
          out_data[j*DATA_W +: DATA_W]  <= load_data[j];
        end else if (out_ready[j]) begin
          out_valid[j] <= 1'b0;
        end
      end
      if (prio_vld && grant[prio]) begin
        rr_ptr <= (prio == PW'(N-1)) ? '0 : prio + PW'(1);
      end
    end
  end
endmodule
